// File: rtl/board_move_executor.sv
// Owns the 8x8 board, queries the move generator and applies validated moves
// (capture, castling rook hop). Optional pawn promotion behind PAWN_PROMOTION_EN.
module board_move_executor #(
  parameter int MASK_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  move_valid,
  output logic                  move_ready,
  input  logic [5:0]            move_from,
  input  logic [5:0]            move_to,
  input  logic [63:0]           possible_moves,
  output logic [3:0]            query_figure,
  output logic [5:0]            query_position,
  output logic [7:0][7:0][3:0]  board,
  output logic                  turn,
  output logic                  move_done,
  output logic                  move_legal,
  output logic [3:0]            captured
);

  // state | meaning
  // IDLE  | waiting for a request, move_ready high
  // QUERY | query outputs held, counting down the mask latency
  // CHECK | sample possible_moves and decide legality
  // APPLY | write board/turn/captured if legal
  // DONE  | move_done pulse, move_legal valid
  typedef enum logic [2:0] {S_IDLE, S_QUERY, S_CHECK, S_APPLY, S_DONE} state_t;

  localparam int CW = (MASK_LATENCY > 1) ? $clog2(MASK_LATENCY + 1) : 1;

  localparam logic [3:0] WHITE_BACK [8] = '{4'h4, 4'h3, 4'h2, 4'h5, 4'h6, 4'h2, 4'h3, 4'h4};
  localparam logic [3:0] BLACK_BACK [8] = '{4'hA, 4'h9, 4'h8, 4'hB, 4'hC, 4'h8, 4'h9, 4'hA};

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [5:0]     from_q;
  logic [5:0]     to_q;
  logic           legal_q;
  logic [3:0]     piece;
  logic [3:0]     placed;
  logic           colour_ok;
  logic           castle;
  logic [5:0]     rook_from;
  logic [5:0]     rook_to;

  function automatic logic [7:0][7:0][3:0] start_board();
    logic [7:0][7:0][3:0] b;
    b = '0;
    for (int c = 0; c < 8; c++) begin
      b[0][c] = BLACK_BACK[c];
      b[1][c] = 4'h7;
      b[6][c] = 4'h1;
      b[7][c] = WHITE_BACK[c];
    end
    return b;
  endfunction

  assign move_ready = (state == S_IDLE);
  assign piece      = board[from_q[5:3]][from_q[2:0]];
  assign colour_ok  = turn ? (piece >= 4'h7 && piece <= 4'hC)
                           : (piece >= 4'h1 && piece <= 4'h6);

  always_comb begin
    placed = piece;
`ifdef PAWN_PROMOTION_EN
    if (piece == 4'h1 && to_q[5:3] == 3'd0) placed = 4'h5;
    if (piece == 4'h7 && to_q[5:3] == 3'd7) placed = 4'hB;
`endif
  end

  // Castling is keyed purely on the king's from/to squares; the rook hops regardless.
  always_comb begin
    castle    = 1'b0;
    rook_from = 6'd0;
    rook_to   = 6'd0;
    if (piece == 4'h6 || piece == 4'hC) begin
      case ({from_q, to_q})
        {6'd60, 6'd62}: begin castle = 1'b1; rook_from = 6'd63; rook_to = 6'd61; end
        {6'd60, 6'd58}: begin castle = 1'b1; rook_from = 6'd56; rook_to = 6'd59; end
        {6'd4,  6'd6 }: begin castle = 1'b1; rook_from = 6'd7;  rook_to = 6'd5;  end
        {6'd4,  6'd2 }: begin castle = 1'b1; rook_from = 6'd0;  rook_to = 6'd3;  end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      board          <= start_board();
      turn           <= 1'b0;
      move_done      <= 1'b0;
      move_legal     <= 1'b0;
      captured       <= 4'h0;
      query_figure   <= 4'h0;
      query_position <= 6'd0;
      from_q         <= 6'd0;
      to_q           <= 6'd0;
      cnt            <= '0;
      legal_q        <= 1'b0;
    end else begin
      move_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (move_valid) begin
            from_q         <= move_from;
            to_q           <= move_to;
            query_figure   <= board[move_from[5:3]][move_from[2:0]];
            query_position <= move_from;
            cnt            <= CW'(MASK_LATENCY);
            state          <= S_QUERY;
          end
        end
        S_QUERY: begin
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= S_CHECK;
        end
        S_CHECK: begin
          legal_q <= (from_q != to_q) && (piece != 4'h0) && colour_ok
                     && possible_moves[to_q];
          state   <= S_APPLY;
        end
        S_APPLY: begin
          if (legal_q) begin
            captured                     <= board[to_q[5:3]][to_q[2:0]];
            board[to_q[5:3]][to_q[2:0]]     <= placed;
            board[from_q[5:3]][from_q[2:0]] <= 4'h0;
            if (castle) begin
              board[rook_to[5:3]][rook_to[2:0]]     <= board[rook_from[5:3]][rook_from[2:0]];
              board[rook_from[5:3]][rook_from[2:0]] <= 4'h0;
            end
            turn <= ~turn;
          end
          move_done  <= 1'b1;
          move_legal <= legal_q;
          state      <= S_DONE;
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/board_move_executor.md
Name: board_move_executor

Overview:
- Owns the 8x8 board register and applies player move requests to it.
- Queries the move generator with the piece code and square, then waits for the 64-bit possible-moves mask.
- Validates the requested destination, then writes the board: capture, castling rook relocation and optional pawn promotion.
- Sits between the input/cursor controller (move requests) and the move generator and display (board consumers).

Parameters:
- MASK_LATENCY, 2, cycles from query outputs changing to possible_moves being valid; minimum 1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- move_valid  in  1  move request present
- move_ready  out  1  executor can accept a request; high only in IDLE
- move_from  in  6  source square; [2:0] column, [5:3] row
- move_to  in  6  destination square, same encoding
- possible_moves  in  64  mask from the move generator; bit n = square n reachable
- query_figure  out  4  piece code presented to the move generator
- query_position  out  6  square presented to the move generator
- board  out  4x8x8  current board, board[row][col]
- turn  out  1  side to move; 0 white, 1 black
- move_done  out  1  one-cycle pulse when a request finishes
- move_legal  out  1  result of the last request; valid while move_done is high, held afterwards
- captured  out  4  code removed from the destination by the last legal move; 0 if none

Behaviour:
- Piece codes: 0 empty; white 1 pawn, 2 bishop, 3 knight, 4 rook, 5 queen, 6 king; black 7 pawn, 8 bishop, 9 knight, A rook, B queen, C king.
- Reset, synchronous, wins over everything:
  - board loads the start position: row 0 = A 9 8 B C 8 9 A; row 1 = all 7; rows 2-5 = 0; row 6 = all 1; row 7 = 4 3 2 5 6 2 3 4.
  - turn = 0, move_done = 0, move_legal = 0, captured = 0, query_figure = 0, query_position = 0.
  - FSM goes to IDLE; any in-flight request is dropped with no board write.
- FSM states: IDLE, QUERY, CHECK, APPLY, DONE.
- IDLE:
  - move_ready = 1.
  - On move_valid & move_ready, latch from/to, register query_figure = board[from] and query_position = from, load the wait counter with MASK_LATENCY, go to QUERY.
- QUERY: decrement the counter each cycle; go to CHECK after exactly MASK_LATENCY cycles. query outputs stay stable throughout.
- CHECK: legal only if all of the following hold:
  - from != to;
  - board[from] != 0;
  - piece colour matches turn: codes 1-6 when turn = 0, 7-C when turn = 1;
  - possible_moves[to] = 1.
  The mask is sampled only in this cycle.
- APPLY, legal request: all writes happen in the same cycle.
  - captured = board[to]; board[to] = board[from]; board[from] = 0; turn toggles.
  - Castling, when the moved piece is a king:
    - 60->62: rook 63->61.
    - 60->58: rook 56->59.
    - 4->6: rook 7->5.
    - 4->2: rook 0->3.
- APPLY, illegal request: no board, turn or captured change.
- DONE: move_done = 1 and move_legal is updated; return to IDLE next cycle.
- Latency: for a request accepted in cycle T, move_done is high in cycle T+MASK_LATENCY+3, and the new board is visible from that same cycle.
- move_valid outside IDLE is ignored. move_from/move_to are don't-care after acceptance.
- Back-to-back requests: the earliest next acceptance is the cycle after DONE.

Optional Feature:
- Macro: PAWN_PROMOTION_EN.
- Defined: in APPLY, a white pawn (1) landing on row 0 is written as 5, and a black pawn (7) landing on row 7 is written as B.
- Undefined: pawns keep their code on every row.

Test Plan:
- Reset, then e2-e4: move_from = 52, move_to = 36, mask bit 36 = 1 -> move_done at T+5 (MASK_LATENCY = 2), move_legal = 1, board[4][4] = 1, board[6][4] = 0, turn = 1, captured = 0.
- Wrong side: with turn = 0, request 12->28 (black pawn) -> move_legal = 0, board unchanged, turn stays 0.
- Mask rejection: 52->20 with possible_moves = 0 -> move_legal = 0, board unchanged; query_position = 52 and query_figure = 1 during QUERY.
- Capture and castle: black knight at 27 captured by a white queen 35->27 -> captured = 9. Separately, with 61 and 62 empty, king 60->62 -> board[7][6] = 6, board[7][5] = 4, board[7][7] = 0, board[7][4] = 0.
- Promotion: white pawn at 8, request 8->0 with mask bit 0 = 1 -> board[0][0] = 5 with PAWN_PROMOTION_EN defined, 1 without.
- Reset mid-operation: assert rst during QUERY -> next cycle start position restored, FSM in IDLE, move_ready = 1, no move_done pulse.
